// File: rtl/swo_word_packer_if.sv
// Word-side handshake of the SWO word packer.
// master drives wordOut/wordLen/wordValid and samples wordReady; slave is the consumer.
interface swo_word_packer_if;
    logic [31:0] wordOut;
    logic [2:0]  wordLen;
    logic        wordValid;
    logic        wordReady;

    modport master (
        output wordOut,
        output wordLen,
        output wordValid,
        input  wordReady
    );

    modport slave (
        input  wordOut,
        input  wordLen,
        input  wordValid,
        output wordReady
    );
endinterface

// File: rtl/swo_word_packer.sv
// SWO word packer: turns the decoder's toggling byteAvail into byte strobes,
// packs bytes little-endian into 32-bit words, flushes partial words after an
// idle timeout and queues words in a first-word-fall-through FIFO.
// Ports: clk, rst (sync, active-high); byteAvail/completeByte from the decoder;
// word_if (wordOut, wordLen, wordValid, wordReady) to the packet layer;
// overflow (sticky drop flag) with clearOverflow; fifoLevel (words held).
module swo_word_packer #(
    parameter int FIFO_AW        = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                byteAvail,
    input  logic [7:0]          completeByte,
    swo_word_packer_if.master   word_if,
    output logic                overflow,
    input  logic                clearOverflow,
    output logic [FIFO_AW:0]    fifoLevel
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] IDLE_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam bit FLUSH_EN = (TIMEOUT_CYCLES != 0);

    logic                avail_prev_q;
    logic [31:0]         acc_q, acc_d;
    logic [1:0]          acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0]    idle_q, idle_d;
    logic                pend_vld_q, pend_vld_d;
    logic [31:0]         pend_word_q, pend_word_d;
    logic [2:0]          pend_len_q, pend_len_d;
    logic [34:0]         mem_q [DEPTH];
    logic [34:0]         mem_d [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]    level_q, level_d;
    logic                overflow_q, overflow_d;

    logic        strobe;
    logic [31:0] acc_with_byte;
    logic        valid;
    logic        pop;
    logic        push_ok;
    logic        drop;

    assign strobe = byteAvail ^ avail_prev_q;
    assign acc_with_byte = acc_q | (32'(completeByte) << {acc_cnt_q, 3'b000});

    // Accumulator, idle timer and the one-cycle pending word stage.
    always_comb begin
        acc_d       = acc_q;
        acc_cnt_d   = acc_cnt_q;
        idle_d      = idle_q;
        pend_vld_d  = 1'b0;
        pend_word_d = pend_word_q;
        pend_len_d  = pend_len_q;
        if (strobe) begin
            // A strobe always beats a coincident timeout.
            idle_d = '0;
            if (acc_cnt_q == 2'd3) begin
                pend_vld_d  = 1'b1;
                pend_word_d = acc_with_byte;
                pend_len_d  = 3'd4;
                acc_d       = '0;
                acc_cnt_d   = 2'd0;
            end else begin
                acc_d     = acc_with_byte;
                acc_cnt_d = acc_cnt_q + 2'd1;
            end
        end else if (acc_cnt_q != 2'd0) begin
            if (FLUSH_EN && idle_q == IDLE_LAST) begin
                pend_vld_d  = 1'b1;
                pend_word_d = acc_q;
                pend_len_d  = {1'b0, acc_cnt_q};
                acc_d       = '0;
                acc_cnt_d   = 2'd0;
                idle_d      = '0;
            end else begin
                idle_d = idle_q + CNT_W'(1);
            end
        end else begin
            idle_d = '0;
        end
    end

    assign valid   = (level_q != '0);
    assign pop     = valid && word_if.wordReady;
    // A full FIFO still takes the word when the head leaves on the same edge.
    assign push_ok = pend_vld_q && ((level_q != DEPTH_L) || pop);
    assign drop    = pend_vld_q && !push_ok;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = {pend_len_q, pend_word_q};
            wr_ptr_d        = wr_ptr_q + FIFO_AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end
        unique case ({push_ok, pop})
            2'b10:   level_d = level_q + (FIFO_AW + 1)'(1);
            2'b01:   level_d = level_q - (FIFO_AW + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clearOverflow) begin
            overflow_d = 1'b0;
        end
    end

    // availPrev tracks byteAvail even in reset so release never fakes a strobe.
    always_ff @(posedge clk) begin
        avail_prev_q <= byteAvail;
        if (rst) begin
            acc_q       <= '0;
            acc_cnt_q   <= '0;
            idle_q      <= '0;
            pend_vld_q  <= 1'b0;
            pend_word_q <= '0;
            pend_len_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            acc_cnt_q   <= acc_cnt_d;
            idle_q      <= idle_d;
            pend_vld_q  <= pend_vld_d;
            pend_word_q <= pend_word_d;
            pend_len_q  <= pend_len_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage needs no reset: the pointers define what is visible.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Empty FIFO presents zeros rather than stale storage.
    assign word_if.wordValid = valid;
    assign word_if.wordOut   = valid ? mem_q[rd_ptr_q][31:0] : 32'd0;
    assign word_if.wordLen   = valid ? mem_q[rd_ptr_q][34:32] : 3'd0;
    assign overflow          = overflow_q;
    assign fifoLevel         = level_q;

endmodule
